fpu_ss_offload_ctrl: RTL and testbench

Offload-side controller for the FPU subsystem. It accepts core offload requests (valid/ready) and drives the instruction into the combinational predecoder. From the predecoder response it decides accept or reject and queues accepted instructions (with rs operand) in a small FIFO toward the FPU decoder. It throttles outstanding integer writebacks and serialises CSR instructions with a drain state machine.

---
 rtl/fpu_ss_pkg.sv | 35 +++
 rtl/fpu_ss_fifo.sv | 72 +++++++
 rtl/fpu_ss_offload_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fpu_ss_offload_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared types and constants for the FPU subsystem offload path
//
// Contents:
//   OpcodeSystem    - major opcode of SYSTEM/CSR instructions
//   MaxIdWidth      - storage width reserved for offload ids inside a queue entry
//   offload_entry_t - one queued instruction on its way to the FPU decoder
//   ctrl_state_e    - offload controller serialisation state
//   is_csr_instr    - true when an instruction belongs to the SYSTEM/CSR opcode space

package fpu_ss_pkg;

    localparam logic [6:0] OpcodeSystem = 7'h73;

    // Entries carry ids up to this width; the controller zero-extends narrower ids.
    localparam int MaxIdWidth = 16;

    typedef struct packed {
        logic [31:0]           instr;
        logic [MaxIdWidth-1:0] id;
        logic [31:0]           rs;
        logic                  wb;
        logic                  mem;
    } offload_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        CSR_BUSY = 2'd2
    } ctrl_state_e;

    function automatic logic is_csr_instr(input logic [31:0] instr);
        return instr[6:0] == OpcodeSystem;
    endfunction

endpackage

// File: rtl/fpu_ss_fifo.sv
// rtl/fpu_ss_fifo.sv - small synchronous FIFO holding accepted offload entries
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (drops all entries)
//   push_i         write push_data_i; ignored while full, even if popping this cycle
//   push_data_i    entry to enqueue
//   full_o         all Depth entries occupied
//   pop_i          drop the head entry; ignored while empty
//   pop_data_o     head entry, held stable until popped
//   empty_o        no entries

module fpu_ss_fifo #(
    parameter type entry_t = logic,
    parameter int  Depth   = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    output logic   full_o,
    input  logic   pop_i,
    output entry_t pop_data_o,
    output logic   empty_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            push_ok;
    logic            pop_ok;

    // Pointers alone cannot tell full from empty, so occupancy is tracked separately.
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

    // A full queue refuses a push even when the head leaves in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign count_d    = count_q + CntW'(push_ok) - CntW'(pop_ok);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Depth is a power of two, so pointer overflow is the modulo wrap.
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the occupancy counter decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fpu_ss_offload_ctrl.sv
// rtl/fpu_ss_offload_ctrl.sv - offload request handshake, writeback throttle and CSR serialisation
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   x_q_*                     core offload request (valid/ready, instr, id, rs1 + rs1 valid)
//   x_k_*                     combinational response to the core (accept, writeback, mem op)
//   prd_instr_o, prd_*_i      combinational predecoder loop
//   issue_*                   FIFO head toward the FPU decoder (valid/ready)
//   wb_done_i                 one integer writeback retired
//   busy_o                    work queued, writebacks outstanding, or serialisation in progress
//   out_wb_cnt_o              accepted-but-unretired writeback instructions

module fpu_ss_offload_ctrl
    import fpu_ss_pkg::*;
#(
    parameter int BufDepth = 4,
    parameter int MaxOutWb = 4,
    parameter int IdWidth  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          x_q_valid_i,
    output logic                          x_q_ready_o,
    input  logic [31:0]                   x_q_instr_i,
    input  logic [IdWidth-1:0]            x_q_id_i,
    input  logic [31:0]                   x_q_rs_i,
    input  logic                          x_q_rs_valid_i,
    output logic                          x_k_accept_o,
    output logic                          x_k_writeback_o,
    output logic                          x_k_is_mem_op_o,
    output logic [31:0]                   prd_instr_o,
    input  logic                          prd_accept_i,
    input  logic                          prd_writeback_i,
    input  logic                          prd_is_mem_op_i,
    input  logic [2:0]                    prd_use_rs_i,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [31:0]                   issue_instr_o,
    output logic [IdWidth-1:0]            issue_id_o,
    output logic [31:0]                   issue_rs_o,
    output logic                          issue_wb_o,
    output logic                          issue_mem_o,
    input  logic                          wb_done_i,
    output logic                          busy_o,
    output logic [$clog2(MaxOutWb+1)-1:0] out_wb_cnt_o
);

    localparam int              CntW   = $clog2(MaxOutWb + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutWb);

    ctrl_state_e     state_q;
    logic [CntW-1:0] wb_cnt_q;
    logic [CntW-1:0] wb_cnt_d;

    offload_entry_t  push_entry;
    offload_entry_t  head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    logic            is_csr;
    logic            drained;
    logic            rs_ok;
    logic            wb_ok;
    logic            state_ok;
    logic            can_accept;
    logic            wb_inc;
    logic            wb_dec;
    logic            unused_bits;

    // ------------------------------------------------------------------
    // Combinational request/response path
    // ------------------------------------------------------------------
    assign prd_instr_o     = x_q_instr_i;
    assign x_k_accept_o    = x_q_valid_i && prd_accept_i;
    assign x_k_writeback_o = x_q_valid_i && prd_writeback_i;
    assign x_k_is_mem_op_o = x_q_valid_i && prd_is_mem_op_i;

    assign is_csr  = is_csr_instr(x_q_instr_i);
    assign drained = fifo_empty && (wb_cnt_q == '0);
    assign rs_ok   = !prd_use_rs_i[0] || x_q_rs_valid_i;
    assign wb_ok   = !prd_writeback_i || (wb_cnt_q < MaxCnt);

    // Only IDLE takes new work; a CSR additionally needs everything older retired.
    always_comb begin
        state_ok = 1'b0;
        if (state_q == IDLE) begin
            state_ok = !is_csr || drained;
        end
    end

    assign can_accept = !fifo_full && rs_ok && wb_ok && state_ok;

    // Rejections are always consumed; accept-type offers wait for can_accept.
    assign x_q_ready_o = x_q_valid_i && (!prd_accept_i || can_accept);
    assign push        = x_q_ready_o && prd_accept_i;

    always_comb begin
        push_entry       = '0;
        push_entry.instr = x_q_instr_i;
        push_entry.id    = MaxIdWidth'(x_q_id_i);
        push_entry.rs    = prd_use_rs_i[0] ? x_q_rs_i : 32'h0;
        push_entry.wb    = prd_writeback_i;
        push_entry.mem   = prd_is_mem_op_i;
    end

    // ------------------------------------------------------------------
    // Issue queue
    // ------------------------------------------------------------------
    fpu_ss_fifo #(
        .entry_t (offload_entry_t),
        .Depth   (BufDepth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .full_o      (fifo_full),
        .pop_i       (pop),
        .pop_data_o  (head),
        .empty_o     (fifo_empty)
    );

    assign pop           = issue_valid_o && issue_ready_i;
    assign issue_valid_o = !fifo_empty;
    assign issue_instr_o = head.instr;
    assign issue_id_o    = head.id[IdWidth-1:0];
    assign issue_rs_o    = head.rs;
    assign issue_wb_o    = head.wb;
    assign issue_mem_o   = head.mem;

    // ------------------------------------------------------------------
    // Outstanding writeback counter and serialisation FSM
    // ------------------------------------------------------------------
    assign wb_inc   = push && prd_writeback_i;
    // A stray retirement with nothing outstanding must not wrap the counter.
    assign wb_dec   = wb_done_i && (wb_cnt_q != '0);
    assign wb_cnt_d = wb_cnt_q + CntW'(wb_inc) - CntW'(wb_dec);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wb_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
            unique case (state_q)
                IDLE: begin
                    // A CSR arriving while older work is in flight holds the port
                    // until the pipeline is empty; one taken on an empty pipeline
                    // blocks further offers until its own writeback retires.
                    if (x_q_valid_i && prd_accept_i && is_csr) begin
                        if (push) begin
                            state_q <= CSR_BUSY;
                        end else if (!drained) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= IDLE;
                    end
                end
                CSR_BUSY: begin
                    if (wb_done_i && (wb_cnt_q == CntW'(1))) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(wb_done_i && (wb_cnt_q == '0)));
        end
    end

    assign busy_o       = !fifo_empty || (wb_cnt_q != '0) || (state_q != IDLE);
    assign out_wb_cnt_o = wb_cnt_q;

    assign unused_bits = ^prd_use_rs_i[2:1] ^ ^(head.id >> IdWidth);

endmodule

// File: tb/tb_fpu_ss_offload_ctrl.sv
// tb/tb_fpu_ss_offload_ctrl.sv - directed and randomized checks of fpu_ss_offload_ctrl
module tb_fpu_ss_offload_ctrl;

    localparam int BufDepth = 4;
    localparam int MaxOutWb = 4;
    localparam int IdWidth  = 4;

    localparam logic [31:0] FADD  = 32'h00208053;
    localparam logic [31:0] FLW   = 32'h0000A007;
    localparam logic [31:0] FMVXW = 32'hE00082D3;
    localparam logic [31:0] FRCSR = 32'h003022F3;

    typedef struct packed {
        logic [31:0]        instr;
        logic [IdWidth-1:0] id;
        logic [31:0]        rs;
        logic               wb;
        logic               mem;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               q_valid;
    logic               q_ready;
    logic [31:0]        q_instr;
    logic [IdWidth-1:0] q_id;
    logic [31:0]        q_rs;
    logic               q_rs_valid;
    logic               k_accept;
    logic               k_wb;
    logic               k_mem;
    logic [31:0]        prd_instr;
    logic               p_accept;
    logic               p_wb;
    logic               p_mem;
    logic [2:0]         p_use_rs;
    logic               iss_valid;
    logic               iss_ready;
    logic [31:0]        iss_instr;
    logic [IdWidth-1:0] iss_id;
    logic [31:0]        iss_rs;
    logic               iss_wb;
    logic               iss_mem;
    logic               wb_done;
    logic               busy;
    logic [2:0]         wb_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_ss_offload_ctrl #(
        .BufDepth (BufDepth),
        .MaxOutWb (MaxOutWb),
        .IdWidth  (IdWidth)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .x_q_valid_i     (q_valid),
        .x_q_ready_o     (q_ready),
        .x_q_instr_i     (q_instr),
        .x_q_id_i        (q_id),
        .x_q_rs_i        (q_rs),
        .x_q_rs_valid_i  (q_rs_valid),
        .x_k_accept_o    (k_accept),
        .x_k_writeback_o (k_wb),
        .x_k_is_mem_op_o (k_mem),
        .prd_instr_o     (prd_instr),
        .prd_accept_i    (p_accept),
        .prd_writeback_i (p_wb),
        .prd_is_mem_op_i (p_mem),
        .prd_use_rs_i    (p_use_rs),
        .issue_valid_o   (iss_valid),
        .issue_ready_i   (iss_ready),
        .issue_instr_o   (iss_instr),
        .issue_id_o      (iss_id),
        .issue_rs_o      (iss_rs),
        .issue_wb_o      (iss_wb),
        .issue_mem_o     (iss_mem),
        .wb_done_i       (wb_done),
        .busy_o          (busy),
        .out_wb_cnt_o    (wb_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_offer();
        q_valid    = 1'b0;
        q_instr    = 32'h0;
        q_id       = '0;
        q_rs       = 32'h0;
        q_rs_valid = 1'b0;
        p_accept   = 1'b0;
        p_wb       = 1'b0;
        p_mem      = 1'b0;
        p_use_rs   = 3'b000;
    endtask

    task automatic offer(input logic [31:0] ins, input logic acc, input logic wb,
                         input logic mem, input logic [IdWidth-1:0] idv);
        q_valid    = 1'b1;
        q_instr    = ins;
        q_id       = idv;
        q_rs       = 32'h0;
        q_rs_valid = 1'b0;
        p_accept   = acc;
        p_wb       = wb;
        p_mem      = mem;
        p_use_rs   = 3'b000;
    endtask

    ent_t mq[$];
    int   mcnt;
    int   mmode;   // 0: free, 1: waiting for pipeline to empty, 2: CSR in flight

    initial begin
        rst = 1'b1;
        clear_offer();
        iss_ready = 1'b0;
        wb_done   = 1'b0;
        tick();
        tick();
        chk("rst_issue_valid", 64'(iss_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_wb_cnt", 64'(wb_cnt), 64'(0));
        chk("rst_ready_idle", 64'(q_ready), 64'(0));
        rst = 1'b0;

        // Plain FP op: same-cycle accept, visible at the issue port one cycle later
        offer(FADD, 1'b1, 1'b0, 1'b0, 4'h1);
        #1;
        chk("fadd_ready", 64'(q_ready), 64'(1));
        chk("fadd_accept", 64'(k_accept), 64'(1));
        chk("fadd_k_wb", 64'(k_wb), 64'(0));
        chk("fadd_prd_instr", 64'(prd_instr), 64'(FADD));
        chk("fadd_no_bypass", 64'(iss_valid), 64'(0));
        tick();
        clear_offer();
        #1;
        chk("fadd_issue_valid", 64'(iss_valid), 64'(1));
        chk("fadd_issue_instr", 64'(iss_instr), 64'(FADD));
        chk("fadd_issue_id", 64'(iss_id), 64'(1));
        chk("fadd_issue_rs", 64'(iss_rs), 64'(0));
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        chk("fadd_popped", 64'(iss_valid), 64'(0));
        chk("fadd_idle_busy", 64'(busy), 64'(0));

        // Rejected instruction is consumed and never queued
        offer(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'h0);
        #1;
        chk("rej_ready", 64'(q_ready), 64'(1));
        chk("rej_accept", 64'(k_accept), 64'(0));
        tick();
        clear_offer();
        #1;
        chk("rej_issue_valid", 64'(iss_valid), 64'(0));
        chk("rej_busy", 64'(busy), 64'(0));

        // Load waits for its rs1 operand
        offer(FLW, 1'b1, 1'b0, 1'b1, 4'h2);
        q_rs     = 32'h1000;
        p_use_rs = 3'b001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("flw_rs_stall", 64'(q_ready), 64'(0));
            tick();
        end
        q_rs_valid = 1'b1;
        #1;
        chk("flw_ready", 64'(q_ready), 64'(1));
        chk("flw_k_mem", 64'(k_mem), 64'(1));
        tick();
        clear_offer();
        #1;
        chk("flw_issue_valid", 64'(iss_valid), 64'(1));
        chk("flw_issue_rs", 64'(iss_rs), 64'(32'h1000));
        chk("flw_issue_mem", 64'(iss_mem), 64'(1));
        chk("flw_issue_wb", 64'(iss_wb), 64'(0));
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;

        // Fill the queue; no push into a full queue even with a pop that cycle
        for (int i = 0; i < 4; i++) begin
            offer(FADD, 1'b1, 1'b0, 1'b0, IdWidth'(i));
            #1;
            chk("fill_ready", 64'(q_ready), 64'(1));
            tick();
        end
        offer(FADD, 1'b1, 1'b0, 1'b0, 4'h4);
        #1;
        chk("full_stall", 64'(q_ready), 64'(0));
        chk("full_busy", 64'(busy), 64'(1));
        iss_ready = 1'b1;
        #1;
        chk("full_no_bypass", 64'(q_ready), 64'(0));
        tick();
        iss_ready = 1'b0;
        #1;
        chk("full_ready_after_pop", 64'(q_ready), 64'(1));
        tick();
        clear_offer();
        for (int i = 1; i <= 4; i++) begin
            iss_ready = 1'b1;
            #1;
            chk("drain_valid", 64'(iss_valid), 64'(1));
            chk("drain_id_order", 64'(iss_id), 64'(i));
            tick();
        end
        iss_ready = 1'b0;
        #1;
        chk("drain_empty", 64'(iss_valid), 64'(0));

        // Writeback throttle
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(FMVXW, 1'b1, 1'b1, 1'b0, IdWidth'(i));
            #1;
            chk("wbfill_ready", 64'(q_ready), 64'(1));
            chk("wbfill_k_wb", 64'(k_wb), 64'(1));
            tick();
        end
        offer(FMVXW, 1'b1, 1'b1, 1'b0, 4'h4);
        #1;
        chk("wb_cnt_max", 64'(wb_cnt), 64'(4));
        chk("wb_limit_stall", 64'(q_ready), 64'(0));
        wb_done = 1'b1;
        #1;
        chk("wb_limit_stall_done", 64'(q_ready), 64'(0));
        tick();
        #1;
        chk("wb_cnt_retire", 64'(wb_cnt), 64'(3));
        chk("wb_ready_again", 64'(q_ready), 64'(1));
        tick();
        wb_done = 1'b0;
        clear_offer();
        #1;
        chk("wb_cnt_push_and_retire", 64'(wb_cnt), 64'(3));
        wb_done = 1'b1;
        repeat (3) tick();
        wb_done = 1'b0;
        #1;
        chk("wb_cnt_zero", 64'(wb_cnt), 64'(0));
        chk("wb_idle_busy", 64'(busy), 64'(0));
        iss_ready = 1'b0;

        // CSR serialisation: drain, accept, block until its writeback retires
        for (int i = 0; i < 2; i++) begin
            offer(FADD, 1'b1, 1'b0, 1'b0, IdWidth'(i));
            #1;
            chk("csr_pre_fill", 64'(q_ready), 64'(1));
            tick();
        end
        offer(FRCSR, 1'b1, 1'b1, 1'b0, 4'h5);
        #1;
        chk("csr_stall_pending", 64'(q_ready), 64'(0));
        tick();
        iss_ready = 1'b1;
        #1;
        chk("csr_stall_drain_a", 64'(q_ready), 64'(0));
        chk("csr_drain_busy", 64'(busy), 64'(1));
        tick();
        #1;
        chk("csr_stall_drain_b", 64'(q_ready), 64'(0));
        tick();
        iss_ready = 1'b0;
        #1;
        chk("csr_stall_drained", 64'(q_ready), 64'(0));
        chk("csr_drained_empty", 64'(iss_valid), 64'(0));
        chk("csr_drain_state_busy", 64'(busy), 64'(1));
        tick();
        #1;
        chk("csr_accept_ready", 64'(q_ready), 64'(1));
        chk("csr_accept", 64'(k_accept), 64'(1));
        tick();
        offer(FADD, 1'b1, 1'b0, 1'b0, 4'h6);
        #1;
        chk("csr_busy_stall", 64'(q_ready), 64'(0));
        chk("csr_issue_instr", 64'(iss_instr), 64'(FRCSR));
        chk("csr_wb_cnt", 64'(wb_cnt), 64'(1));
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        chk("csr_busy_stall_empty", 64'(q_ready), 64'(0));
        chk("csr_busy_flag", 64'(busy), 64'(1));
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        #1;
        chk("csr_exit_ready", 64'(q_ready), 64'(1));
        tick();
        clear_offer();
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        chk("csr_done_busy", 64'(busy), 64'(0));

        // Reset mid-operation drops entries and counts
        offer(FMVXW, 1'b1, 1'b1, 1'b0, 4'h7);
        tick();
        tick();
        clear_offer();
        #1;
        chk("midrst_pre_cnt", 64'(wb_cnt), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_issue_valid", 64'(iss_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_wb_cnt", 64'(wb_cnt), 64'(0));

        // Randomized traffic against a queue-based reference model
        mq.delete();
        mcnt  = 0;
        mmode = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic csr;
            logic drained;
            logic st_ok;
            logic exp_ready;
            logic push;
            int   sz;
            ent_t head;
            csr        = ($urandom_range(0, 7) == 0);
            q_valid    = ($urandom_range(0, 3) != 0);
            q_instr    = $urandom;
            if (csr) q_instr[6:0] = 7'h73;
            else if (q_instr[6:0] == 7'h73) q_instr[6:0] = 7'h53;
            q_id       = IdWidth'($urandom);
            q_rs       = $urandom;
            q_rs_valid = ($urandom_range(0, 3) != 0);
            p_accept   = ($urandom_range(0, 4) != 0);
            p_wb       = csr ? 1'b1 : 1'($urandom_range(0, 1));
            p_mem      = 1'($urandom_range(0, 1));
            p_use_rs   = 3'($urandom);
            iss_ready  = 1'($urandom_range(0, 1));
            wb_done    = (mcnt > 0) && ($urandom_range(0, 2) == 0);
            #1;
            sz        = mq.size();
            drained   = (sz == 0) && (mcnt == 0);
            st_ok     = (mmode == 0) && (!csr || drained);
            exp_ready = q_valid && (!p_accept || ((sz < BufDepth) && (!p_use_rs[0] || q_rs_valid)
                        && (!p_wb || mcnt < MaxOutWb) && st_ok));
            push      = exp_ready && p_accept;
            chk("rnd_ready", 64'(q_ready), 64'(exp_ready));
            chk("rnd_accept", 64'(k_accept), 64'(q_valid && p_accept));
            chk("rnd_k_wb", 64'(k_wb), 64'(q_valid && p_wb));
            chk("rnd_k_mem", 64'(k_mem), 64'(q_valid && p_mem));
            chk("rnd_prd_instr", 64'(prd_instr), 64'(q_instr));
            chk("rnd_issue_valid", 64'(iss_valid), 64'(sz > 0));
            if (sz > 0) begin
                head = mq[0];
                chk("rnd_issue_instr", 64'(iss_instr), 64'(head.instr));
                chk("rnd_issue_id", 64'(iss_id), 64'(head.id));
                chk("rnd_issue_rs", 64'(iss_rs), 64'(head.rs));
                chk("rnd_issue_wb", 64'(iss_wb), 64'(head.wb));
                chk("rnd_issue_mem", 64'(iss_mem), 64'(head.mem));
            end
            chk("rnd_busy", 64'(busy), 64'(sz > 0 || mcnt > 0 || mmode != 0));
            chk("rnd_wb_cnt", 64'(wb_cnt), 64'(mcnt));

            if (mmode == 0 && q_valid && p_accept && csr) mmode = push ? 2 : (drained ? 0 : 1);
            else if (mmode == 1 && drained) mmode = 0;
            else if (mmode == 2 && wb_done && mcnt == 1) mmode = 0;
            if (iss_ready && sz > 0) void'(mq.pop_front());
            if (push) mq.push_back('{instr: q_instr, id: q_id, rs: (p_use_rs[0] ? q_rs : 32'h0),
                                     wb: p_wb, mem: p_mem});
            mcnt = mcnt + int'(push && p_wb) - int'(wb_done);
            tick();
        end
        clear_offer();
        iss_ready = 1'b0;
        wb_done   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
